// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core memory request at a time, formats it for a
// word-addressed memory bus, waits for ack (bounded by TIMEOUT) and returns results.
module load_store_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_rdata_valid,
    output logic [31:0] o_rdata,
    output logic        o_store_done,
    output logic        o_fault,
    output logic [1:0]  o_fault_code,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          is_load_q;
    logic [2:0]    funct3_q;
    logic [1:0]    offset_q;

    logic          type_ok;
    logic          funct3_ok;
    logic          aligned;
    logic [3:0]    be_fmt;
    logic [31:0]   wdata_fmt;
    logic [31:0]   shifted;
    logic [31:0]   load_val;

    assign o_busy = (state == WAIT);

    // Request decode: legality, alignment and bus formatting of the incoming access.
    always_comb begin
        type_ok = i_is_load ^ i_is_store;
        if (i_is_load)
            funct3_ok = (i_funct3 != 3'b011) && (i_funct3[2:1] != 2'b11);
        else
            funct3_ok = !i_funct3[2] && (i_funct3[1:0] != 2'b11);
        case (i_funct3[1:0])
            2'b00: begin
                aligned   = 1'b1;
                be_fmt    = 4'b0001 << i_addr[1:0];
                wdata_fmt = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                aligned   = !i_addr[0];
                be_fmt    = 4'b0011 << i_addr[1:0];
                wdata_fmt = {2{i_wdata[15:0]}};
            end
            default: begin
                aligned   = (i_addr[1:0] == 2'b00);
                be_fmt    = 4'b1111;
                wdata_fmt = i_wdata;
            end
        endcase
    end

    // Extract the addressed lane from the returned word and extend it.
    always_comb begin
        shifted = i_mem_rdata >> {offset_q, 3'b000};
        case (funct3_q[1:0])
            2'b00:   load_val = {{24{~funct3_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{~funct3_q[2] & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            is_load_q     <= 1'b0;
            funct3_q      <= 3'b000;
            offset_q      <= 2'b00;
            o_mem_req     <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_wdata   <= '0;
            o_mem_be      <= 4'b0000;
            o_rdata       <= '0;
            o_rdata_valid <= 1'b0;
            o_store_done  <= 1'b0;
            o_fault       <= 1'b0;
            o_fault_code  <= 2'b00;
        end else begin
            o_rdata_valid <= 1'b0;
            o_store_done  <= 1'b0;
            o_fault       <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        if (!(type_ok && funct3_ok)) begin
                            o_fault      <= 1'b1;
                            o_fault_code <= 2'b11;
                        end else if (!aligned) begin
                            o_fault      <= 1'b1;
                            o_fault_code <= 2'b01;
                        end else begin
                            state       <= WAIT;
                            wait_cnt    <= '0;
                            is_load_q   <= i_is_load;
                            funct3_q    <= i_funct3;
                            offset_q    <= i_addr[1:0];
                            o_mem_req   <= 1'b1;
                            o_mem_we    <= i_is_store;
                            o_mem_addr  <= {i_addr[31:2], 2'b00};
                            o_mem_be    <= be_fmt;
                            o_mem_wdata <= i_is_store ? wdata_fmt : 32'h0;
                        end
                    end
                end
                WAIT: begin
                    // Ack wins over a simultaneous timeout.
                    if (i_mem_ack) begin
                        state     <= IDLE;
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                        if (is_load_q) begin
                            o_rdata       <= load_val;
                            o_rdata_valid <= 1'b1;
                        end else begin
                            o_store_done <= 1'b1;
                        end
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        state        <= IDLE;
                        o_mem_req    <= 1'b0;
                        o_mem_we     <= 1'b0;
                        o_fault      <= 1'b1;
                        o_fault_code <= 2'b10;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
